// File: rtl/pll_lock_ctrl_if.sv
// -----------------------------------------------------------------------------
// pll_lock_ctrl_if
//
// Purpose:
//   Bundles the PLL-facing and system-facing signals of the lock controller.
//   The controller sees the asynchronous PLL lock indication. It drives the PLL
//   reset pin, the system reset, the status flags and the two event counters.
//
// Signals:
//   lock        PLL lock indication, asynchronous to clkin
//   pll_reset   active-high reset to the PLL reset pin
//   rst_out     active-high system reset in the clkin domain
//   locked_ok   high only while the controller is in RUN
//   state       2-bit state: RESET_PLL=0, WAIT_LOCK=1, RUN=2
//   retry_count saturating count of lock timeouts
//   lost_count  saturating count of lock losses seen in RUN
//
// Modports:
//   master  the PLL / environment side (drives lock, observes status)
//   slave   the controller side (receives lock, drives status)
// -----------------------------------------------------------------------------
interface pll_lock_ctrl_if;

  logic       lock;
  logic       pll_reset;
  logic       rst_out;
  logic       locked_ok;
  logic [1:0] state;
  logic [7:0] retry_count;
  logic [7:0] lost_count;

  // The environment owns the lock input and only observes the status.
  modport master (
    output lock,
    input  pll_reset,
    input  rst_out,
    input  locked_ok,
    input  state,
    input  retry_count,
    input  lost_count
  );

  // The controller consumes lock and owns every status output.
  modport slave (
    input  lock,
    output pll_reset,
    output rst_out,
    output locked_ok,
    output state,
    output retry_count,
    output lost_count
  );

endinterface

// File: rtl/pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// pll_lock_ctrl
//
// Purpose:
//   Brings a PLL out of reset and gates the system reset on a stable lock.
//   Each attempt holds the PLL in reset for RST_CYCLES cycles. It then waits
//   for STABLE_CYCLES consecutive synchronized lock-high cycles before it
//   releases the system reset. If lock does not settle within TIMEOUT_CYCLES,
//   the attempt is retried. Once running, a lock-low run of GLITCH_CYCLES
//   cycles counts as a loss of lock and starts a new attempt. Shorter lock
//   dips are ignored.
//
// Ports:
//   clkin   free-running reference clock, the only clock
//   reset   asynchronous active-high reset
//   bus     pll_lock_ctrl_if.slave (lock in; pll_reset, rst_out, locked_ok,
//           state, retry_count and lost_count out)
//
// Parameters:
//   RST_CYCLES     cycles pll_reset stays asserted per attempt
//   STABLE_CYCLES  consecutive lock_s-high cycles required before RUN
//   TIMEOUT_CYCLES maximum WAIT_LOCK dwell before a retry
//   GLITCH_CYCLES  consecutive lock_s-low cycles in RUN that count as a loss
// -----------------------------------------------------------------------------
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 270000,
  parameter int unsigned GLITCH_CYCLES  = 4
) (
  input  logic            clkin,
  input  logic            reset,
  pll_lock_ctrl_if.slave  bus
);

  // The counters must hold the largest threshold. One spare bit keeps every
  // compare value below the counter's wrap point.
  localparam int unsigned MAX_AB = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned MAX_CD = (TIMEOUT_CYCLES > GLITCH_CYCLES) ? TIMEOUT_CYCLES : GLITCH_CYCLES;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  // The cycle counter counts from 0. The last cycle of a dwell is therefore
  // threshold-1, so the dwell lasts exactly the threshold. The stable and
  // low run counters are compared at the threshold itself. The move then
  // happens on the edge after the run completes.
  localparam logic [CW-1:0] C_ONE          = CW'(1);
  localparam logic [CW-1:0] C_RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_STABLE       = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] C_GLITCH       = CW'(GLITCH_CYCLES);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_lockMeta;
  logic          r_lockS;
  logic [CW-1:0] r_cycleCnt;
  logic [CW-1:0] r_runCnt;
  logic [7:0]    r_retryCnt;
  logic [7:0]    r_lostCnt;

  // This block holds the whole controller: the lock synchronizer, the state
  // register and every counter.
  //
  // The synchronizer is held clear while the PLL is in reset. Lock from a PLL
  // held in reset means nothing. Clearing the flops also makes each attempt
  // start from lock_s=0, so lock latency is counted from WAIT_LOCK entry.
  //
  // r_cycleCnt is the per-state dwell counter, and it clears on every state
  // entry. r_runCnt is the stable-high counter in WAIT_LOCK and the low run
  // counter in RUN. It also clears on every entry.
  //
  // In WAIT_LOCK the stable test comes before the timeout test. When both
  // thresholds land in the same cycle, RUN wins and no retry is counted.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state    <= RESET_PLL;
      r_lockMeta <= 1'b0;
      r_lockS    <= 1'b0;
      r_cycleCnt <= '0;
      r_runCnt   <= '0;
      r_retryCnt <= 8'd0;
      r_lostCnt  <= 8'd0;
    end else begin
      if (r_state == RESET_PLL) begin
        r_lockMeta <= 1'b0;
        r_lockS    <= 1'b0;
      end else begin
        r_lockMeta <= bus.lock;
        r_lockS    <= r_lockMeta;
      end

      case (r_state)
        RESET_PLL: begin
          if (r_cycleCnt == C_RST_LAST) begin
            r_state    <= WAIT_LOCK;
            r_cycleCnt <= '0;
            r_runCnt   <= '0;
          end else begin
            r_cycleCnt <= r_cycleCnt + C_ONE;
          end
        end

        WAIT_LOCK: begin
          if (r_runCnt == C_STABLE) begin
            r_state    <= RUN;
            r_cycleCnt <= '0;
            r_runCnt   <= '0;
          end else if (r_cycleCnt == C_TIMEOUT_LAST) begin
            r_state    <= RESET_PLL;
            r_cycleCnt <= '0;
            r_runCnt   <= '0;
            if (r_retryCnt != 8'hFF) begin
              r_retryCnt <= r_retryCnt + 8'd1;
            end
          end else begin
            r_cycleCnt <= r_cycleCnt + C_ONE;
            if (r_lockS) begin
              r_runCnt <= r_runCnt + C_ONE;
            end else begin
              r_runCnt <= '0;
            end
          end
        end

        RUN: begin
          if (r_runCnt == C_GLITCH) begin
            r_state    <= RESET_PLL;
            r_cycleCnt <= '0;
            r_runCnt   <= '0;
            if (r_lostCnt != 8'hFF) begin
              r_lostCnt <= r_lostCnt + 8'd1;
            end
          end else if (r_lockS) begin
            r_runCnt <= '0;
          end else begin
            r_runCnt <= r_runCnt + C_ONE;
          end
        end

        default: begin
          r_state    <= RESET_PLL;
          r_cycleCnt <= '0;
          r_runCnt   <= '0;
        end
      endcase
    end
  end

  // The outputs decode the state register directly. The async reset forces
  // RESET_PLL, so rst_out and pll_reset rise without waiting for a clock edge.
  assign bus.state       = r_state;
  assign bus.pll_reset   = (r_state == RESET_PLL);
  assign bus.rst_out     = (r_state != RUN);
  assign bus.locked_ok   = (r_state == RUN);
  assign bus.retry_count = r_retryCnt;
  assign bus.lost_count  = r_lostCnt;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_ctrl
//
// Purpose:
//   Directed bench for pll_lock_ctrl with RST_CYCLES=4, STABLE_CYCLES=8,
//   TIMEOUT_CYCLES=32 and GLITCH_CYCLES=3.
//
//   Inputs change 1 time unit after a rising edge, and outputs are sampled at
//   that same point. A lock value driven in cycle c is therefore seen as
//   lock_s in cycle c+2. A threshold run that completes in cycle n moves the
//   state on the edge that ends cycle n.
// -----------------------------------------------------------------------------
module tb_pll_lock_ctrl;

  logic clkin;
  logic reset;
  int   total;
  int   bad;

  pll_lock_ctrl_if bus ();

  pll_lock_ctrl #(
    .RST_CYCLES     (4),
    .STABLE_CYCLES  (8),
    .TIMEOUT_CYCLES (32),
    .GLITCH_CYCLES  (3)
  ) dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running reference clock with rising edges at 5, 15, 25, ...
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  // Restart the controller through reset with lock low. On return the
  // controller has just entered WAIT_LOCK and is in cycle 0 of that state.
  task automatic enterWaitLock();
    bus.lock = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();
  endtask

  // While reset is held, the controller sits in RESET_PLL with cleared counts.
  task automatic test_reset();
    reset = 1'b1;
    bus.lock = 1'b0;
    repeat (2) step();
    total++;
    if (bus.state !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %0d want 0", bus.state);
    end
    total++;
    if ({bus.pll_reset, bus.rst_out, bus.locked_ok} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b want 110", {bus.pll_reset, bus.rst_out, bus.locked_ok});
    end
    total++;
    if ({bus.retry_count, bus.lost_count} !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset_counts: retry=%0d lost=%0d want 0/0", bus.retry_count, bus.lost_count);
    end
  endtask

  // With lock high from the start, the pll_reset pulse lasts 4 cycles and
  // RUN is entered 2+8+1 cycles after WAIT_LOCK entry.
  task automatic test_clean_start();
    bus.lock = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      total++;
      if (bus.state !== ((i < 4) ? 2'd0 : 2'd1) || bus.pll_reset !== (i < 4)) begin
        bad++;
        $display("[TB] FAIL clean_pulse step %0d: state=%0d pll_reset=%b", i, bus.state, bus.pll_reset);
      end
    end
    for (int i = 1; i <= 11; i++) begin
      step();
      total++;
      if (bus.state !== ((i < 11) ? 2'd1 : 2'd2)) begin
        bad++;
        $display("[TB] FAIL clean_wait step %0d: state=%0d want %0d", i, bus.state, (i < 11) ? 1 : 2);
      end
    end
    total++;
    if ({bus.pll_reset, bus.rst_out, bus.locked_ok} !== 3'b001 || bus.retry_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL clean_run: outs=%b retry=%0d want 001/0", {bus.pll_reset, bus.rst_out, bus.locked_ok}, bus.retry_count);
    end
  endtask

  // A 2-cycle lock drop in RUN is ignored. A 3-cycle drop is a loss: the
  // state moves to RESET_PLL 6 edges after the drop, lost_count goes to 1,
  // and the controller relocks.
  task automatic test_glitch();
    bus.lock = 1'b0;
    step();
    step();
    bus.lock = 1'b1;
    for (int i = 3; i <= 12; i++) begin
      step();
      total++;
      if (bus.state !== 2'd2 || bus.lost_count !== 8'd0 || bus.rst_out !== 1'b0) begin
        bad++;
        $display("[TB] FAIL glitch_short step %0d: state=%0d lost=%0d rst_out=%b", i, bus.state, bus.lost_count, bus.rst_out);
      end
    end
    bus.lock = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 3) bus.lock = 1'b1;
      total++;
      if (bus.state !== ((i < 6) ? 2'd2 : 2'd0)) begin
        bad++;
        $display("[TB] FAIL glitch_loss step %0d: state=%0d want %0d", i, bus.state, (i < 6) ? 2 : 0);
      end
    end
    total++;
    if (bus.rst_out !== 1'b1 || bus.locked_ok !== 1'b0 || bus.lost_count !== 8'd1) begin
      bad++;
      $display("[TB] FAIL glitch_lost: rst_out=%b locked_ok=%b lost=%0d want 1/0/1", bus.rst_out, bus.locked_ok, bus.lost_count);
    end
    for (int i = 1; i <= 15; i++) begin
      step();
      total++;
      if (bus.state !== ((i < 4) ? 2'd0 : (i < 15) ? 2'd1 : 2'd2)) begin
        bad++;
        $display("[TB] FAIL glitch_relock step %0d: state=%0d", i, bus.state);
      end
    end
    total++;
    if (bus.lost_count !== 8'd1 || bus.retry_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL glitch_counts: lost=%0d retry=%0d want 1/0", bus.lost_count, bus.retry_count);
    end
  endtask

  // Reset asserted between edges in RUN takes effect at once and clears the
  // counts. A fresh 4-cycle pll_reset pulse follows the release.
  task automatic test_async_reset();
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (bus.state !== 2'd0 || bus.rst_out !== 1'b1 || bus.pll_reset !== 1'b1 || bus.locked_ok !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_outputs: state=%0d rst_out=%b pll_reset=%b locked_ok=%b", bus.state, bus.rst_out, bus.pll_reset, bus.locked_ok);
    end
    total++;
    if (bus.lost_count !== 8'd0 || bus.retry_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL async_counts: lost=%0d retry=%0d want 0/0", bus.lost_count, bus.retry_count);
    end
    step();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      total++;
      if (bus.state !== ((i < 4) ? 2'd0 : 2'd1) || bus.pll_reset !== (i < 4)) begin
        bad++;
        $display("[TB] FAIL async_pulse step %0d: state=%0d pll_reset=%b", i, bus.state, bus.pll_reset);
      end
    end
  endtask

  // Lock is high for 7 cycles, low for 1, then high. The dip clears the
  // stable count at 7, so RUN arrives on edge 19 instead of edge 11.
  task automatic test_chatter();
    enterWaitLock();
    for (int c = 0; c <= 18; c++) begin
      bus.lock = (c == 7) ? 1'b0 : 1'b1;
      step();
      total++;
      if (bus.state !== ((c + 1 < 19) ? 2'd1 : 2'd2)) begin
        bad++;
        $display("[TB] FAIL chatter edge %0d: state=%0d want %0d", c + 1, bus.state, (c + 1 < 19) ? 1 : 2);
      end
    end
    total++;
    if (bus.retry_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL chatter_retry: got %0d want 0", bus.retry_count);
    end
  endtask

  // Lock rising in cycle 21 completes 8 stable cycles exactly as the timeout
  // expires at edge 32, and RUN wins. Rising one cycle later lets the timeout
  // fire first.
  task automatic test_simultaneous();
    enterWaitLock();
    for (int c = 0; c <= 31; c++) begin
      bus.lock = (c >= 21);
      step();
      total++;
      if (bus.state !== ((c + 1 < 32) ? 2'd1 : 2'd2)) begin
        bad++;
        $display("[TB] FAIL simul_tie edge %0d: state=%0d want %0d", c + 1, bus.state, (c + 1 < 32) ? 1 : 2);
      end
    end
    total++;
    if (bus.retry_count !== 8'd0 || bus.locked_ok !== 1'b1) begin
      bad++;
      $display("[TB] FAIL simul_tie_end: retry=%0d locked_ok=%b want 0/1", bus.retry_count, bus.locked_ok);
    end
    enterWaitLock();
    for (int c = 0; c <= 31; c++) begin
      bus.lock = (c >= 22);
      step();
      total++;
      if (bus.state !== ((c + 1 < 32) ? 2'd1 : 2'd0)) begin
        bad++;
        $display("[TB] FAIL simul_late edge %0d: state=%0d want %0d", c + 1, bus.state, (c + 1 < 32) ? 1 : 0);
      end
    end
    total++;
    if (bus.retry_count !== 8'd1) begin
      bad++;
      $display("[TB] FAIL simul_late_retry: got %0d want 1", bus.retry_count);
    end
  endtask

  // With lock held low, each attempt is 32 WAIT_LOCK cycles plus a 4-cycle
  // pulse. retry_count climbs 1, 2, 3, ... and holds at 255.
  task automatic test_no_lock();
    enterWaitLock();
    for (int k = 1; k <= 260; k++) begin
      repeat (31) step();
      if (k <= 3) begin
        total++;
        if (bus.state !== 2'd1) begin
          bad++;
          $display("[TB] FAIL nolock_wait attempt %0d: state=%0d want 1", k, bus.state);
        end
      end
      step();
      if (k <= 3 || k >= 254) begin
        total++;
        if (bus.state !== 2'd0 || bus.retry_count !== ((k < 255) ? k[7:0] : 8'd255)) begin
          bad++;
          $display("[TB] FAIL nolock_retry attempt %0d: state=%0d retry=%0d want 0/%0d", k, bus.state, bus.retry_count, (k < 255) ? k : 255);
        end
      end
      repeat (3) step();
      if (k <= 3) begin
        total++;
        if (bus.pll_reset !== 1'b1) begin
          bad++;
          $display("[TB] FAIL nolock_pulse attempt %0d: pll_reset=%b want 1", k, bus.pll_reset);
        end
      end
      step();
      if (k <= 3) begin
        total++;
        if (bus.state !== 2'd1 || bus.pll_reset !== 1'b0) begin
          bad++;
          $display("[TB] FAIL nolock_rewait attempt %0d: state=%0d pll_reset=%b", k, bus.state, bus.pll_reset);
        end
      end
    end
    total++;
    if (bus.lost_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL nolock_lost: got %0d want 0", bus.lost_count);
    end
  endtask

  // Scenarios run in order. The glitch test leaves the controller in RUN
  // with lost_count=1, which the async reset test relies on.
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.lock = 1'b0;
    $display("[TB] starting pll_lock_ctrl bench");
    test_reset();
    test_clean_start();
    test_glitch();
    test_async_reset();
    test_chatter();
    test_simultaneous();
    test_no_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
